// File: rtl/sr_mdu_pkg.sv
// Shared definitions for the schoolRISCV iterative multiply/divide unit.
// Opcode encodings and field widths live here so that decode and the MDU agree.
package sr_mdu_pkg;

  localparam int MDU_OPER_W = 2;

  typedef enum logic [MDU_OPER_W-1:0] {
    MDU_MUL   = 2'd0,
    MDU_MULHU = 2'd1,
    MDU_DIVU  = 2'd2,
    MDU_REMU  = 2'd3
  } mdu_oper_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

  // Divide ops share the upper opcode bit.
  function automatic logic oper_is_div(input mdu_oper_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/sr_mdu_step.sv
// One combinational iteration of the shared shift-add multiply / restoring divide datapath.
// acc_hi doubles as the remainder; shreg holds the multiplier (mul) or dividend->quotient (div).
module sr_mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] shreg,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] acc_hi_next,
  output logic [XLEN-1:0] acc_lo_next,
  output logic [XLEN-1:0] shreg_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
  logic          q_bit;

  always_comb begin
    sum   = {1'b0, acc_hi} + (shreg[0] ? {1'b0, opnd} : '0);
    // 33-bit trial keeps the shifted-out remainder MSB when the divisor exceeds 2^31.
    trial = {acc_hi, shreg[XLEN-1]};
    diff  = trial - {1'b0, opnd};
    q_bit = (trial >= {1'b0, opnd});

    acc_hi_next = acc_hi;
    acc_lo_next = acc_lo;
    shreg_next  = shreg;

    if (is_div) begin
      acc_hi_next = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
      shreg_next  = {shreg[XLEN-2:0], q_bit};
    end else begin
      acc_hi_next = sum[XLEN:1];
      acc_lo_next = {sum[0], acc_lo[XLEN-1:1]};
      shreg_next  = {1'b0, shreg[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/sr_mdu.sv
// Iterative 32-cycle multiply/divide unit: FSM, iteration counter and registered response.
// Accepts in IDLE, iterates in BUSY, holds the result in DONE until writeback takes it.
module sr_mdu
  import sr_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_oper,
  input  logic [XLEN-1:0] req_srcA,
  input  logic [XLEN-1:0] req_srcB,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_zero,
  output logic [4:0]      resp_rd
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  mdu_state_t      state_reg, state_next;
  mdu_oper_t       oper_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] acc_hi_reg, acc_lo_reg, shreg_reg, opnd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0] result_reg;
  logic            zero_reg;
  logic [4:0]      resp_rd_reg;

  logic [XLEN-1:0] acc_hi_next, acc_lo_next, shreg_next;
  logic [XLEN-1:0] result_next;
  logic            accept, finish, last_iter, req_is_div;

  assign req_is_div = oper_is_div(mdu_oper_t'(req_oper));
  assign last_iter  = (cnt_reg == CNT_W'(XLEN - 1));

  sr_mdu_step #(.XLEN(XLEN)) u_step (
    .is_div      (oper_is_div(oper_reg)),
    .acc_hi      (acc_hi_reg),
    .acc_lo      (acc_lo_reg),
    .shreg       (shreg_reg),
    .opnd        (opnd_reg),
    .acc_hi_next (acc_hi_next),
    .acc_lo_next (acc_lo_next),
    .shreg_next  (shreg_next)
  );

  always_comb begin
    case (oper_reg)
      MDU_MUL:   result_next = acc_lo_next;
      MDU_MULHU: result_next = acc_hi_next;
      MDU_DIVU:  result_next = shreg_next;
      default:   result_next = acc_hi_next;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = ST_BUSY;
          accept     = 1'b1;
        end
      end
      ST_BUSY: begin
        if (last_iter) begin
          state_next = ST_DONE;
          finish     = 1'b1;
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Abort wins over everything, including a simultaneous request.
    if (flush) begin
      state_next = ST_IDLE;
      accept     = 1'b0;
      finish     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oper_reg    <= MDU_MUL;
      rd_reg      <= '0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      shreg_reg   <= '0;
      opnd_reg    <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b1;
      resp_rd_reg <= '0;
    end else begin
      if (accept) begin
        oper_reg   <= mdu_oper_t'(req_oper);
        rd_reg     <= req_rd;
        acc_hi_reg <= '0;
        acc_lo_reg <= '0;
        cnt_reg    <= '0;
        shreg_reg  <= req_is_div ? req_srcA : req_srcB;
        opnd_reg   <= req_is_div ? req_srcB : req_srcA;
      end else if (state_reg == ST_BUSY && !flush) begin
        acc_hi_reg <= acc_hi_next;
        acc_lo_reg <= acc_lo_next;
        shreg_reg  <= shreg_next;
        cnt_reg    <= cnt_reg + 1'b1;
      end
      if (finish) begin
        result_reg  <= result_next;
        zero_reg    <= (result_next == '0);
        resp_rd_reg <= rd_reg;
      end
    end
  end

  assign resp_result = result_reg;
  assign resp_zero   = zero_reg;
  assign resp_rd     = resp_rd_reg;

endmodule
